serial_full_subtractor: RTL

- Bit-serial N-bit full subtractor: computes diff = a − b − bin and borrow-out bout, one bit per clock, LSB first.
- Counterpart to the team's parallel N-bit full-adder datapath; covers the subtract direction in area-constrained paths that tolerate N-cycle latency.
- Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake.

---
 rtl/serial_full_subtractor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_full_subtractor
// Purpose  : Bit-serial N-bit subtractor, diff = a - b - bin, LSB first,
//            with valid/ready handshakes on both sides.
// Option   : define SERIAL_FULL_SUBTRACTOR_SIGNED_EN to enable the ovf flag.
// Revision : 1.0
// ============================================================================
module serial_full_subtractor #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         ovf
);

   localparam int                CNT_W  = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [N-1:0]     r_diff;
   logic             r_br;
   logic             r_bout;
   logic [CNT_W-1:0] r_cnt;

   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_br_next;
   logic             w_last;
   logic [N:0]       w_cat;

   assign w_ai      = r_a[0];
   assign w_bi      = r_b[0];
   assign w_d       = w_ai ^ w_bi ^ r_br;
   assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
   assign w_last    = (r_cnt == C_LAST);
   // New difference bit enters at the MSB; slicing the concatenation keeps N=1 legal.
   assign w_cat     = {w_d, r_diff};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_diff  <= '0;
         r_br    <= 1'b0;
         r_bout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_br    <= bin;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a    <= r_a >> 1;
               r_b    <= r_b >> 1;
               r_br   <= w_br_next;
               r_diff <= w_cat[N:1];
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_bout  <= w_br_next;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SERIAL_FULL_SUBTRACTOR_SIGNED_EN
   logic r_ovf;

   // Signed overflow: borrow into the MSB differs from borrow out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN && w_last) begin
         r_ovf <= r_br ^ w_br_next;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign diff      = r_diff;
   assign bout      = r_bout;

endmodule
`default_nettype wire
